// File: rtl/spi_ram.sv
// spi_ram: single-port byte RAM fed by an SPI slave's 10-bit received words.
// Each word is {cmd[1:0], payload[7:0]}. The commands set the write pointer,
// write a byte (with pointer auto-increment), set the read pointer, or read a
// byte (with pointer auto-increment). Read bytes go back to the slave on dout,
// qualified by a one-cycle tx_valid strobe.
//
// Handshake: rx_valid is a single-cycle strobe with no back-pressure. A word
// is consumed on every rising edge where rx_valid=1, and din is ignored
// otherwise. tx_valid is also a strobe with no ready. It is high for exactly
// the cycle after each read-data command, and dout is valid while it is high.
// When tx_valid is low, dout holds its last value.
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8   // 1..8, and MEM_DEPTH must equal 2**ADDR_SIZE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  localparam logic [ADDR_SIZE-1:0] ADDR_ONE = 1;

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  cmd_e                 cmd;
  logic [7:0]           payload;
  logic                 do_write;

  assign cmd      = cmd_e'(din[9:8]);
  assign payload  = din[7:0];
  // A write is suppressed while reset is held, because the storage array has no reset.
  assign do_write = rst_n && rx_valid && (cmd == CMD_WR_DATA);

  // Storage array. Its contents are deliberately not reset, so they survive rst_n.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_addr] <= payload;
    end
  end

  // Pointer update, read-data capture and the one-cycle tx_valid strobe.
  // Both pointers wrap naturally at ADDR_SIZE bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      dout     <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      if (rx_valid) begin
        case (cmd)
          CMD_WR_ADDR: wr_addr <= payload[ADDR_SIZE-1:0];
          CMD_WR_DATA: wr_addr <= wr_addr + ADDR_ONE;
          CMD_RD_ADDR: rd_addr <= payload[ADDR_SIZE-1:0];
          CMD_RD_DATA: begin
            dout     <= mem[rd_addr];
            rd_addr  <= rd_addr + ADDR_ONE;
            tx_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram.sv
// tb_spi_ram: directed and random command streams for spi_ram in its default
// 256-byte configuration and in a 16-byte configuration. A plain array-based
// model of the RAM and its two pointers predicts dout and tx_valid.
module tb_spi_ram;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] din = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] dout;
  logic       tx_valid;
  logic [9:0] din4 = '0;
  logic       rx_valid4 = 1'b0;
  logic [7:0] dout4;
  logic       tx_valid4;

  always #5 clk = ~clk;

  spi_ram u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout), .tx_valid(tx_valid)
  );

  spi_ram #(.MEM_DEPTH(16), .ADDR_SIZE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .rx_valid(rx_valid4),
    .dout(dout4), .tx_valid(tx_valid4)
  );

  // ---------------- reference model ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m  [256];
  logic [7:0] m4 [16];
  int         wp = 0, rp = 0, wp4 = 0, rp4 = 0;
  logic [7:0] exp_dout = 8'h00, exp_dout4 = 8'h00;
  logic       exp_tx = 1'b0, exp_tx4 = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle on the 256-byte instance: drive at negedge, predict, check after posedge.
  task automatic cyc(input bit rv, input bit [1:0] c, input bit [7:0] p);
    @(negedge clk);
    din = {c, p};
    rx_valid = rv;
    exp_tx = 1'b0;
    if (rv) begin
      case (c)
        2'b00: wp = p;
        2'b01: begin m[wp] = p; wp = (wp + 1) % 256; end
        2'b10: rp = p;
        2'b11: begin exp_dout = m[rp]; rp = (rp + 1) % 256; exp_tx = 1'b1; end
      endcase
    end
    @(posedge clk);
    #1;
    chk("tx_valid", {7'b0, tx_valid}, {7'b0, exp_tx});
    chk("dout", dout, exp_dout);
  endtask

  // Same for the 16-byte instance; the address is the payload modulo 16.
  task automatic cyc4(input bit rv, input bit [1:0] c, input bit [7:0] p);
    @(negedge clk);
    din4 = {c, p};
    rx_valid4 = rv;
    exp_tx4 = 1'b0;
    if (rv) begin
      case (c)
        2'b00: wp4 = p % 16;
        2'b01: begin m4[wp4] = p; wp4 = (wp4 + 1) % 16; end
        2'b10: rp4 = p % 16;
        2'b11: begin exp_dout4 = m4[rp4]; rp4 = (rp4 + 1) % 16; exp_tx4 = 1'b1; end
      endcase
    end
    @(posedge clk);
    #1;
    chk("tx_valid4", {7'b0, tx_valid4}, {7'b0, exp_tx4});
    chk("dout4", dout4, exp_dout4);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    // reset state
    #1;
    chk("reset_dout", dout, 8'h00);
    chk("reset_tx", {7'b0, tx_valid}, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // fill the whole RAM with random data so every later read is defined
    cyc(1, 2'b00, 8'h00);
    for (int i = 0; i < 256; i++) cyc(1, 2'b01, 8'($urandom_range(0, 255)));

    // basic write then read, and tx_valid lasts exactly one cycle
    cyc(1, 2'b00, 8'h05);
    cyc(1, 2'b01, 8'hA5);
    cyc(1, 2'b10, 8'h05);
    cyc(1, 2'b11, 8'h00);
    chk("basic_read", dout, 8'hA5);
    cyc(0, 2'b00, 8'h00);

    // burst write across the top of the address space, then back-to-back reads
    cyc(1, 2'b00, 8'hFE);
    cyc(1, 2'b01, 8'h11);
    cyc(1, 2'b01, 8'h22);
    cyc(1, 2'b01, 8'h33);
    cyc(1, 2'b10, 8'hFE);
    cyc(1, 2'b11, 8'h00);
    chk("burst0", dout, 8'h11);
    cyc(1, 2'b11, 8'h00);
    chk("burst1", dout, 8'h22);
    cyc(1, 2'b11, 8'h00);
    chk("burst2_wrap", dout, 8'h33);
    cyc(0, 2'b11, 8'h00);

    // write and read commands carried while rx_valid=0 must be ignored
    for (int i = 0; i < 20; i++) cyc(0, (i % 2) ? 2'b11 : 2'b01, 8'($urandom_range(0, 255)));
    cyc(1, 2'b10, 8'h05);
    cyc(1, 2'b11, 8'h00);
    chk("idle_kept", dout, 8'hA5);

    // asynchronous reset while tx_valid is high; then a write attempt held in reset
    cyc(1, 2'b11, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("async_tx", {7'b0, tx_valid}, 8'h00);
    chk("async_dout", dout, 8'h00);
    exp_dout = 8'h00; exp_tx = 1'b0; wp = 0; rp = 0;
    exp_dout4 = 8'h00; exp_tx4 = 1'b0; wp4 = 0; rp4 = 0;
    @(negedge clk);
    din = {2'b01, 8'hEE};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n = 1'b1;
    cyc(1, 2'b10, 8'h05);
    cyc(1, 2'b11, 8'h00);
    chk("retained", dout, 8'hA5);
    cyc(1, 2'b10, 8'h00);
    cyc(1, 2'b11, 8'h00);
    chk("no_write_in_reset", dout, 8'h33);

    // independent pointers
    cyc(1, 2'b00, 8'h10);
    cyc(1, 2'b10, 8'h20);
    cyc(1, 2'b01, 8'h77);
    cyc(1, 2'b11, 8'h00);
    cyc(1, 2'b10, 8'h10);
    cyc(1, 2'b11, 8'h00);
    chk("interleave", dout, 8'h77);

    // read-after-write to the same address on consecutive cycles
    cyc(1, 2'b00, 8'h40);
    cyc(1, 2'b10, 8'h40);
    cyc(1, 2'b01, 8'h9C);
    cyc(1, 2'b11, 8'h00);
    chk("raw", dout, 8'h9C);

    // random command stream
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    cyc(0, 2'b00, 8'h00);

    // 16-byte configuration: fill, upper payload bits ignored, pointer wrap
    cyc4(1, 2'b00, 8'h00);
    for (int i = 0; i < 16; i++) cyc4(1, 2'b01, 8'($urandom_range(0, 255)));
    cyc4(1, 2'b00, 8'hFF);
    cyc4(1, 2'b01, 8'h5A);
    cyc4(1, 2'b10, 8'h0F);
    cyc4(1, 2'b11, 8'h00);
    chk("small_read", dout4, 8'h5A);
    cyc4(1, 2'b01, 8'hC3);
    cyc4(1, 2'b10, 8'hF0);
    cyc4(1, 2'b11, 8'h00);
    chk("small_wrap", dout4, 8'hC3);
    for (int i = 0; i < 100; i++)
      cyc4(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    cyc4(0, 2'b00, 8'h00);

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
